// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: test-pattern source placed after the VGA timing generator.
// It derives pixel (x, y) from the DE/H_Sync/V_Sync stream, generates registered RGB for one of
// four patterns, and forwards DE and syncs delay-matched to the RGB (2-cycle latency throughout).
//
// Optional build macro: VGA_PAT_BORDER_EN forces a white one-pixel border around the active area.
//
// Ports:
//   clk, rst                 pixel clock, synchronous active-high reset
//   H_Act, V_Act             active pixels per line / lines per frame (static within a frame)
//   mode                     0 colour bars, 1 scrolling checker, 2 gradient, 3 grid
//   DE_in, H_Sync_in,
//   V_Sync_in                timing stream from the timing generator
//   DE_out, H_Sync_out,
//   V_Sync_out               timing stream delayed 2 cycles
//   R_out, G_out, B_out      pixel colour, aligned with DE_out
//   frame_cnt                V_Sync_in rising edges seen (wraps at 255)
module vga_pattern_gen #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CHK_LOG2 = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       H_Act,
  input  logic [15:0]       V_Act,
  input  logic [1:0]        mode,
  input  logic              DE_in,
  input  logic              H_Sync_in,
  input  logic              V_Sync_in,
  output logic              DE_out,
  output logic              H_Sync_out,
  output logic              V_Sync_out,
  output logic [DATA_W-1:0] R_out,
  output logic [DATA_W-1:0] G_out,
  output logic [DATA_W-1:0] B_out,
  output logic [7:0]        frame_cnt
);

  localparam logic [DATA_W-1:0] Full = '1;

  // Stage 1 state
  logic        de1, hs1, vs1;
  logic [15:0] x1, y1, bar_cnt1;
  logic [2:0]  bar_idx1;
  logic [1:0]  mode_lat;

  logic        vs_rise, de_fall;
  logic [15:0] bar_w, x_d, y_d, bar_cnt_d;
  logic [2:0]  bar_idx_d;
  logic [7:0]  frame_cnt_d;
  logic [1:0]  mode_lat_d;

  logic [15:0]       chk_sum;
  logic              chk_white;
  logic [DATA_W-1:0] r_d, g_d, b_d;

  // de1/vs1 double as the previous-cycle samples for edge detection.
  assign vs_rise = V_Sync_in & ~vs1;
  assign de_fall = ~DE_in & de1;

  // Bar width is H_Act/8 by shift; a zero width would never advance, so clamp to 1.
  always_comb begin
    bar_w = {3'b000, H_Act[15:3]};
    if (bar_w == 16'd0) bar_w = 16'd1;
  end

  always_comb begin
    x_d       = 16'd0;
    bar_cnt_d = 16'd0;
    bar_idx_d = 3'd0;
    if (DE_in && de1) begin
      x_d       = x1 + 16'd1;
      bar_idx_d = bar_idx1;
      if (bar_cnt1 == bar_w - 16'd1) begin
        bar_cnt_d = 16'd0;
        bar_idx_d = (bar_idx1 == 3'd7) ? 3'd7 : bar_idx1 + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt1 + 16'd1;
      end
    end

    y_d = y1;
    if (vs_rise) begin
      y_d = 16'd0;
    end else if (de_fall) begin
      y_d = y1 + 16'd1;
    end

    frame_cnt_d = vs_rise ? frame_cnt + 8'd1 : frame_cnt;
    mode_lat_d  = vs_rise ? mode : mode_lat;
  end

  // Stage 2 colour generation
  assign chk_sum   = x1 + {8'd0, frame_cnt};
  assign chk_white = (chk_sum[CHK_LOG2] == y1[CHK_LOG2]);

`ifdef VGA_PAT_BORDER_EN
  logic border;
  assign border = (x1 == 16'd0) || (x1 == H_Act - 16'd1) ||
                  (y1 == 16'd0) || (y1 == V_Act - 16'd1);
  logic unused_bits;
  assign unused_bits = ^chk_sum[15:CHK_LOG2+1];
`else
  logic unused_bits;
  assign unused_bits = ^{chk_sum[15:CHK_LOG2+1], H_Act[2:0], V_Act};
`endif

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (de1) begin
      unique case (mode_lat)
        // Bar order white, yellow, cyan, green, magenta, red, blue, black maps to inverted index bits.
        2'd0: begin
          r_d = {DATA_W{~bar_idx1[1]}};
          g_d = {DATA_W{~bar_idx1[2]}};
          b_d = {DATA_W{~bar_idx1[0]}};
        end
        2'd1: begin
          if (chk_white) begin
            r_d = Full;
            g_d = Full;
            b_d = Full;
          end
        end
        2'd2: begin
          r_d = x1[DATA_W-1:0];
          g_d = x1[DATA_W-1:0];
          b_d = x1[DATA_W-1:0];
        end
        2'd3: begin
          b_d = Full;
          if ((x1[CHK_LOG2-1:0] == '0) || (y1[CHK_LOG2-1:0] == '0)) begin
            r_d = Full;
            g_d = Full;
          end
        end
      endcase
`ifdef VGA_PAT_BORDER_EN
      if (border) begin
        r_d = Full;
        g_d = Full;
        b_d = Full;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      de1        <= 1'b0;
      hs1        <= 1'b0;
      vs1        <= 1'b0;
      x1         <= 16'd0;
      y1         <= 16'd0;
      bar_cnt1   <= 16'd0;
      bar_idx1   <= 3'd0;
      mode_lat   <= 2'd0;
      frame_cnt  <= 8'd0;
      DE_out     <= 1'b0;
      H_Sync_out <= 1'b0;
      V_Sync_out <= 1'b0;
      R_out      <= '0;
      G_out      <= '0;
      B_out      <= '0;
    end else begin
      de1        <= DE_in;
      hs1        <= H_Sync_in;
      vs1        <= V_Sync_in;
      x1         <= x_d;
      y1         <= y_d;
      bar_cnt1   <= bar_cnt_d;
      bar_idx1   <= bar_idx_d;
      mode_lat   <= mode_lat_d;
      frame_cnt  <= frame_cnt_d;
      DE_out     <= de1;
      H_Sync_out <= hs1;
      V_Sync_out <= vs1;
      R_out      <= r_d;
      G_out      <= g_d;
      B_out      <= b_d;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: the driver computes expected outputs from a behavioural
// model and queues them with a due cycle; a monitor pops and compares every cycle.
module tb_vga_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] H_Act, V_Act;
  logic [1:0]  mode;
  logic        DE_in, H_Sync_in, V_Sync_in;
  logic        DE_out, H_Sync_out, V_Sync_out;
  logic [7:0]  R_out, G_out, B_out;
  logic [7:0]  frame_cnt;

  vga_pattern_gen dut (
    .clk        (clk),
    .rst        (rst),
    .H_Act      (H_Act),
    .V_Act      (V_Act),
    .mode       (mode),
    .DE_in      (DE_in),
    .H_Sync_in  (H_Sync_in),
    .V_Sync_in  (V_Sync_in),
    .DE_out     (DE_out),
    .H_Sync_out (H_Sync_out),
    .V_Sync_out (V_Sync_out),
    .R_out      (R_out),
    .G_out      (G_out),
    .B_out      (B_out),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          due;
    logic        de, hs, vs;
    logic [23:0] rgb;
    int          mode, ha, va, x, y, fc;
  } exp_t;
  typedef struct {
    int due;
    int fc;
  } fc_t;

  exp_t pix_q[$];
  fc_t  fc_q[$];

  // Reference model state (what has been seen on the input stream so far)
  int         m_x = 0, m_y = 0, m_mode = 0, m_fc = 0;
  bit         m_pde = 0, m_pvs = 0;
  int         next_ha = 1920, next_va = 12;
  logic [1:0] next_mode = 2'd0;

  function automatic logic [23:0] pattern(input int md, input int x, input int y, input int fc,
                                          input int ha, input int va);
    int bw, idx, s;
    logic [23:0] c;
    c = 24'h000000;
    case (md)
      0: begin
        bw = ha / 8;
        if (bw < 1) bw = 1;
        idx = x / bw;
        if (idx > 7) idx = 7;
        case (idx)
          0:       c = 24'hFFFFFF;
          1:       c = 24'hFFFF00;
          2:       c = 24'h00FFFF;
          3:       c = 24'h00FF00;
          4:       c = 24'hFF00FF;
          5:       c = 24'hFF0000;
          6:       c = 24'h0000FF;
          default: c = 24'h000000;
        endcase
      end
      1: begin
        s = (x + fc) % 65536;
        c = (((s / 32) % 2) == ((y / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
      end
      2: c = {x[7:0], x[7:0], x[7:0]};
      default: c = ((x % 32 == 0) || (y % 32 == 0)) ? 24'hFFFFFF : 24'h0000FF;
    endcase
`ifdef VGA_PAT_BORDER_EN
    if (x == 0 || x == ha - 1 || y == 0 || y == va - 1) c = 24'hFFFFFF;
`endif
    return c;
  endfunction

  // Hand-derived values at selected pixels, independent of the model above.
  function automatic bit spot_exp(input exp_t e, output logic [23:0] v);
    bit hit;
    hit = 1'b0;
    v   = 24'h000000;
    if (e.de && e.mode == 0 && e.ha == 1920 && (e.y == 3 || e.y == 8)) begin
      case (e.x)
        0, 239:     begin hit = 1'b1; v = 24'hFFFFFF; end
        240:        begin hit = 1'b1; v = 24'hFFFF00; end
        1440:       begin hit = 1'b1; v = 24'h0000FF; end
        1680, 1918: begin hit = 1'b1; v = 24'h000000; end
        default:    hit = 1'b0;
      endcase
    end
    if (e.de && e.mode == 2 && e.ha == 1920) begin
      if (e.y == 10) begin
        case (e.x)
          300:  begin hit = 1'b1; v = 24'h2C2C2C; end
          1918: begin hit = 1'b1; v = 24'h7E7E7E; end
`ifdef VGA_PAT_BORDER_EN
          1919: begin hit = 1'b1; v = 24'hFFFFFF; end
`else
          1919: begin hit = 1'b1; v = 24'h7F7F7F; end
`endif
          default: hit = 1'b0;
        endcase
      end
`ifdef VGA_PAT_BORDER_EN
      if (e.y == 0 || e.y == e.va - 1) begin
        hit = 1'b1;
        v   = 24'hFFFFFF;
      end
`endif
    end
    if (e.de && e.mode == 1 && e.ha == 64 && e.fc == 3 && e.y == 1) begin
      if (e.x == 28) begin hit = 1'b1; v = 24'hFFFFFF; end
      if (e.x == 29) begin hit = 1'b1; v = 24'h000000; end
    end
    return hit;
  endfunction

  // One input cycle: drive DUT, advance model, queue expectations.
  task automatic drive(input bit r, input bit de, input bit hs, input bit vs);
    exp_t e;
    fc_t  f;
    bit   vs_rise, de_fall;
    @(posedge clk);
    #1;
    rst       = r;
    DE_in     = de;
    H_Sync_in = hs;
    V_Sync_in = vs;
    mode      = next_mode;
    H_Act     = next_ha[15:0];
    V_Act     = next_va[15:0];
    e         = '{default: 0};
    if (r) begin
      m_x = 0; m_y = 0; m_mode = 0; m_fc = 0; m_pde = 0; m_pvs = 0;
      // Everything is cleared at the next edge, including what was already in flight.
      if (pix_q.size() > 0 && pix_q[pix_q.size()-1].due == cyc + 1) void'(pix_q.pop_back());
      if (fc_q.size() > 0 && fc_q[fc_q.size()-1].due == cyc + 1) void'(fc_q.pop_back());
      e.due = cyc + 1;
      pix_q.push_back(e);
      e.due = cyc + 2;
      pix_q.push_back(e);
      f.due = cyc + 1;
      f.fc  = 0;
      fc_q.push_back(f);
    end else begin
      vs_rise = vs && !m_pvs;
      de_fall = !de && m_pde;
      if (de) m_x = m_pde ? (m_x + 1) % 65536 : 0;
      else    m_x = 0;
      if (vs_rise)      m_y = 0;
      else if (de_fall) m_y = (m_y + 1) % 65536;
      if (vs_rise) begin
        m_fc   = (m_fc + 1) % 256;
        m_mode = int'(next_mode);
      end
      e.due  = cyc + 2;
      e.de   = de;
      e.hs   = hs;
      e.vs   = vs;
      e.mode = m_mode;
      e.ha   = next_ha;
      e.va   = next_va;
      e.x    = m_x;
      e.y    = m_y;
      e.fc   = m_fc;
      e.rgb  = de ? pattern(m_mode, m_x, m_y, m_fc, next_ha, next_va) : 24'h000000;
      pix_q.push_back(e);
      f.due = cyc + 1;
      f.fc  = m_fc;
      fc_q.push_back(f);
      m_pde = de;
      m_pvs = vs;
    end
  endtask

  task automatic line(input int act, input int blank, input bit vs);
    for (int i = 0; i < act; i++) drive(1'b0, 1'b1, 1'b0, vs);
    for (int i = 0; i < blank; i++) drive(1'b0, 1'b0, (i >= 2 && i < 6), vs);
  endtask

  task automatic run_frame(input int ha, input int va, input int hblank, input int sw_line,
                           input logic [1:0] sw_mode);
    next_ha = ha;
    next_va = va;
    for (int l = 0; l < 3; l++) line(0, 40, (l == 1 || l == 2));
    for (int l = 0; l < va; l++) begin
      if (l == sw_line) next_mode = sw_mode;
      line(ha, hblank, 1'b0);
    end
  endtask

  // Monitor
  exp_t        mon_e;
  fc_t         mon_f;
  logic [23:0] spot_v;

  initial begin
    forever begin
      @(posedge clk);
      #3;
      while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
        mon_e = pix_q.pop_front();
        if (mon_e.due == cyc) begin
          checks++;
          if ({DE_out, H_Sync_out, V_Sync_out} !== {mon_e.de, mon_e.hs, mon_e.vs} ||
              {R_out, G_out, B_out} !== mon_e.rgb) begin
            errors++;
            $display("FAIL pixel cyc=%0d x=%0d y=%0d got de/hs/vs=%b%b%b rgb=%h want %b%b%b rgb=%h",
                     cyc, mon_e.x, mon_e.y, DE_out, H_Sync_out, V_Sync_out,
                     {R_out, G_out, B_out}, mon_e.de, mon_e.hs, mon_e.vs, mon_e.rgb);
          end
          if (spot_exp(mon_e, spot_v)) begin
            checks++;
            if ({R_out, G_out, B_out} !== spot_v) begin
              errors++;
              $display("FAIL spot mode=%0d x=%0d y=%0d got rgb=%h want rgb=%h",
                       mon_e.mode, mon_e.x, mon_e.y, {R_out, G_out, B_out}, spot_v);
            end
          end
        end
      end
      while (fc_q.size() > 0 && fc_q[0].due <= cyc) begin
        mon_f = fc_q.pop_front();
        if (mon_f.due == cyc) begin
          checks++;
          if (frame_cnt !== 8'(mon_f.fc)) begin
            errors++;
            $display("FAIL frame_cnt cyc=%0d got %0d want %0d", cyc, frame_cnt, mon_f.fc);
          end
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    DE_in     = 1'b0;
    H_Sync_in = 1'b0;
    V_Sync_in = 1'b0;
    mode      = 2'd0;
    H_Act     = 16'd1920;
    V_Act     = 16'd12;

    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);

    // 1080p-width bars, mode change to gradient mid-frame, then the gradient frame.
    next_mode = 2'd0;
    run_frame(1920, 12, 16, 5, 2'd2);
    run_frame(1920, 12, 16, -1, 2'd2);

    // Reset asserted for two cycles in the middle of a line.
    next_ha = 64;
    next_va = 4;
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    line(0, 10, 1'b0);
    line(64, 12, 1'b0);

    // Scrolling checker over four frames.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    next_mode = 2'd1;
    for (int f = 0; f < 4; f++) run_frame(64, 4, 12, -1, 2'd1);

    // Randomized streams including single-cycle pulses, random mode and occasional reset.
    for (int seg = 0; seg < 2; seg++) begin
      next_ha = (seg == 0) ? 20 : 5;
      next_va = 7;
      for (int i = 0; i < 400; i++) begin
        if (($urandom % 20) == 0) next_mode = 2'($urandom_range(0, 3));
        drive((($urandom % 60) == 0), (($urandom % 4) != 0), (($urandom % 8) == 0),
              (($urandom % 12) == 0));
      end
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    end

    // frame_cnt wraps back to 0 after 256 V_Sync_in rises.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL frame_cnt_wrap got %0d want 0", frame_cnt);
    end

    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
